gpio_bcd_display: RTL
=====================

// Module: gpio_bcd_display
// PURPOSE
//  Downstream consumer of the CPU GPIO_out port. Converts each 32-bit unsigned value the CPU
//  writes into NUM_DIGITS decimal digits on active-low seven-segment outputs (board HEX displays).
//  Uses sequential double-dabble (one shift/add-3 step per clock) instead of a wide combinational divider.
// PARAMETERS
//  NUM_DIGITS  8  displayed digits; the internal scratch is always 10 BCD digits (covers 2^32-1)
//  BLANK_LZ    1  1 = blank leading zeros (digit 0 is always shown); 0 = show all zeros
// PORTS
//  clk        in   1              system clock, rising edge
//  rst_n      in   1              asynchronous reset, ACTIVE-HIGH (1 = reset)
//  gpio_out   in   32             value driven by CPU GPIO_out, unsigned
//  gpio_we    in   1              1-cycle strobe: gpio_out is valid this cycle
//  hex_out    out  NUM_DIGITS*7   digit i at [7i+6:7i], segments {g,f,e,d,c,b,a}, active-low
//  busy       out  1              conversion in progress
//  overflow   out  1              last displayed value exceeded NUM_DIGITS decimal digits
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, overflow=0, pend_vld=0, every hex_out digit=7'h7F (blank).
//  FSM states: IDLE, SHIFT, LOAD.
//   IDLE : on gpio_we at edge E0 -> capture gpio_out into shift reg, clear the 40-bit BCD scratch,
//          step count=0, busy=1, go to SHIFT. A write of an unchanged value still reconverts.
//   SHIFT: each edge: first add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
//          After the 32nd step (edge E32) go to LOAD.
//   LOAD : edge E33 -> hex_out, overflow updated from scratch; busy=0; go to IDLE unless a restart applies.
//  Latency: write accepted at E0 -> new hex_out visible after E33 (33 cycles); busy high E0..E33.
//  Writes while busy (SHIFT/LOAD): stored in 1-entry pending reg (pend_val, pend_vld=1).
//   Last write wins; the conversion in flight is never aborted.
//  Restart at LOAD edge: if gpio_we OR pend_vld -> source = gpio_we ? gpio_out : pend_val.
//   Display updates from the finished conversion and the new conversion is accepted on the same
//   edge (E33 acts as its E0). pend_vld clears; busy stays 1.
//  Overflow: any scratch digit index >= NUM_DIGITS nonzero -> overflow=1 and all digits show
//   dash 7'b0111111. Otherwise overflow=0.
//  Blanking (BLANK_LZ=1): digit i>0 shows 7'h7F if it and all higher digits are 0.
//  Segment codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000 dash=0111111 blank=1111111.
//  All outputs are registered; hex_out changes only at a LOAD edge or on reset.
//  Reset mid-conversion: result and pending write are discarded; display returns to blank.
// TESTING
//  1 assert rst_n 2 cycles, release -> hex_out all 7'h7F, busy=0, overflow=0.
//  2 gpio_we with 32'd0 -> busy=1 for 34 edges; then digit0=1000000, digits1..7 blank.
//  3 gpio_we with 32'h00BC614E (12345678) -> after 33 cycles digits7..0 = 1,2,3,4,5,6,7,8 codes, overflow=0.
//  4 gpio_we with 32'd100000000 -> overflow=1, all 8 digits 0111111; then 32'd42 -> overflow=0, shows "42".
//  5 write 32'd7, then 32'd5 and 32'd9 while busy -> "7" shown at E33, second conversion starts at E33,
//    "9" shown 33 cycles later; "5" never shown.
//  6 write 32'd123, assert rst_n at step 10 -> blank, busy=0; no later update without a new write.

Source files
------------

// File: rtl/gpio_bcd_display.sv
// Turns each 32-bit value written on the CPU GPIO port into NUM_DIGITS active-low seven-segment digits.
// The conversion is sequential double-dabble: one add-3/shift step per clock, 33 cycles per write.
module gpio_bcd_display #(
    parameter int NUM_DIGITS = 8,    // 1..10; the scratch always holds 10 BCD digits
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,     // asynchronous, active-high despite the name
    input  logic [31:0]             gpio_out,
    input  logic                    gpio_we,
    output logic [NUM_DIGITS*7-1:0] hex_out,
    output logic                    busy,
    output logic                    overflow
);

    localparam int SCR_DIGITS = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]                state;
    logic [31:0]               bin;
    logic [4*SCR_DIGITS-1:0]   bcd;
    logic [4:0]                step;
    logic [31:0]               pend_val;
    logic                      pend_vld;

    logic [4*SCR_DIGITS-1:0]   bcd_adj;
    logic [4*SCR_DIGITS+31:0]  shifted;
    logic [NUM_DIGITS*7-1:0]   disp;
    logic                      disp_ovf;
    logic                      seen_nz;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < SCR_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // The top scratch bit is never set for a 32-bit input, so dropping it on the shift is safe.
    assign shifted = {bcd_adj, bin} << 1;

    always_comb begin
        disp_ovf = 1'b0;
        seen_nz  = 1'b0;
        disp     = '0;
        for (int i = NUM_DIGITS; i < SCR_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                disp_ovf = 1'b1;
        end
        // Walk from the most significant digit down so seen_nz marks the end of leading zeros.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0)
                seen_nz = 1'b1;
            if (disp_ovf)
                disp[7*i +: 7] = SEG_DASH;
            else if (BLANK_LZ && !seen_nz && i != 0)
                disp[7*i +: 7] = SEG_BLANK;
            else
                disp[7*i +: 7] = seg7(bcd[4*i +: 4]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            bin      <= '0;
            bcd      <= '0;
            step     <= '0;
            pend_val <= '0;
            pend_vld <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            hex_out  <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gpio_we) begin
                        bin   <= gpio_out;
                        bcd   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd  <= shifted[4*SCR_DIGITS+31:32];
                    bin  <= shifted[31:0];
                    step <= step + 5'd1;
                    if (step == 5'd31)
                        state <= ST_LOAD;
                    if (gpio_we) begin
                        pend_val <= gpio_out;
                        pend_vld <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    hex_out  <= disp;
                    overflow <= disp_ovf;
                    pend_vld <= 1'b0;
                    // A write arriving on this very edge is newer than anything pending.
                    if (gpio_we || pend_vld) begin
                        bin   <= gpio_we ? gpio_out : pend_val;
                        bcd   <= '0;
                        step  <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
